uart_fifo_tx: RTL

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

---
 rtl/uart_fifo_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_tx.sv
// UART transmitter (8N1) fed by a byte FIFO; every byte passes through the FIFO.
// Latency: a byte written into an empty FIFO while idle drives the start bit from the next edge.
// Backpressure: none to the writer; writes while full are dropped and flagged by a one-cycle overflow pulse.
//
// Ports:
//   clock460800 - single clock (460800 Hz -> 115200 baud at OVERSAMPLE=4)
//   reset       - synchronous active-high reset
//   data/write  - byte and enqueue strobe (one byte per asserted cycle)
//   full/count  - FIFO full flag and occupancy
//   overflow    - one-cycle pulse after a dropped write
//   busy        - frame in progress or FIFO non-empty
//   UART_TX     - registered serial line, idle high
module uart_fifo_tx #(
  parameter int DEPTH_LOG2 = 3,
  parameter int OVERSAMPLE = 4
) (
  input  logic                  clock460800,
  input  logic                  reset,
  input  logic [7:0]            data,
  input  logic                  write,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  UART_TX
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNTW  = DEPTH_LOG2 + 1;
  localparam int CW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0]   LP_BIT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CNTW-1:0] LP_FULL     = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CNTW-1:0]       r_count;
  logic                  r_overflow;

  state_t                r_state;
  logic [CW-1:0]         r_bitcnt;
  logic [2:0]            r_bitidx;
  logic [7:0]            r_shift;
  logic                  r_tx;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_bitcnt_nxt;
  logic [2:0]            w_bitidx_nxt;
  logic [7:0]            w_shift_nxt;
  logic                  w_tx_nxt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_bit_end;

  // Full comes from the registered count, so a pop on the same edge does not rescue a write.
  assign w_full    = (r_count == LP_FULL);
  assign w_push    = write & ~w_full;
  assign w_bit_end = (r_bitcnt == LP_BIT_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_bitidx_nxt = r_bitidx;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt     = 1'b1;
        w_bitcnt_nxt = '0;
        w_bitidx_nxt = '0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bitcnt_nxt = '0;
          w_bitidx_nxt = '0;
          w_tx_nxt     = r_shift[0];
          w_state_nxt  = S_DATA;
        end else begin
          w_bitcnt_nxt = r_bitcnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bitcnt_nxt = '0;
          if (r_bitidx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            // Shift register keeps the current bit at [0]; next bit is [1].
            w_bitidx_nxt = r_bitidx + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_tx_nxt     = r_shift[1];
          end
        end else begin
          w_bitcnt_nxt = r_bitcnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_bitcnt_nxt = '0;
          // Back-to-back frames: go straight to the next start bit.
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_bitcnt_nxt = r_bitcnt + CW'(1);
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock460800) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_bitidx   <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_bitidx   <= w_bitidx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_overflow <= write & w_full;
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock460800) begin
    if (!reset && w_push) r_mem[r_wptr] <= data;
  end

  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) || (r_count != '0);
  assign UART_TX  = r_tx;

endmodule
